// File: rtl/compute_read_load.sv
// Loads one 256-coefficient polynomial from a 64-bit FIFO into a dual-port coefficient RAM.
// Define COEF_LOAD_REDUCE_EN to reduce coefficients modulo 8380417 through one extra stage.
module compute_read_load (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    output logic        load_working,
    output logic        load_done,
    output logic        load_error,
    input  logic        Read_FIFO_tvalid,
    input  logic [63:0] Read_FIFO_tdata,
    output logic        Read_FIFO_tready,
    output logic        coef_ena,
    output logic        coef_wea,
    output logic [7:0]  coef_addra,
    output logic [22:0] coef_dina,
    output logic        coef_enb,
    output logic        coef_web,
    output logic [7:0]  coef_addrb,
    output logic [22:0] coef_dinb
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t      state;
    logic [6:0]  beat_cnt;
    logic        accept;
    logic        pad_err;
    logic        last_beat;
    logic        pipe_busy;
    logic [22:0] c_even;
    logic [22:0] c_odd;

    // tready depends on state only, so the FIFO never sees a combinational loop through tvalid.
    assign Read_FIFO_tready = (state == LOAD);
    assign accept           = Read_FIFO_tvalid && Read_FIFO_tready;
    assign pad_err          = (|Read_FIFO_tdata[63:55]) || (|Read_FIFO_tdata[31:23]);
    assign last_beat        = (beat_cnt == 7'd127);
    assign c_even           = Read_FIFO_tdata[22:0];
    assign c_odd            = Read_FIFO_tdata[54:32];

`ifdef COEF_LOAD_REDUCE_EN
    localparam logic [22:0] MOD_Q = 23'd8380417;

    logic        s1_valid;
    logic [6:0]  s1_cnt;
    logic [22:0] s1_even;
    logic [22:0] s1_odd;

    function automatic logic [22:0] reduce(input logic [22:0] c);
        return (c >= MOD_Q) ? (c - MOD_Q) : c;
    endfunction

    // The reduce stage still holds a beat that has not reached the RAM ports.
    assign pipe_busy = s1_valid;
`else
    assign pipe_busy = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= 7'd0;
            load_working <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state        <= LOAD;
                        beat_cnt     <= 7'd0;
                        load_error   <= 1'b0;
                        load_working <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last_beat) state <= FLUSH;
                        else           beat_cnt <= beat_cnt + 7'd1;
                        if (pad_err)   load_error <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (!pipe_busy) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    load_done    <= 1'b0;
                    load_working <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM write port drive; enables pulse only on write cycles, address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_ena   <= 1'b0;
            coef_wea   <= 1'b0;
            coef_addra <= 8'd0;
            coef_dina  <= 23'd0;
            coef_enb   <= 1'b0;
            coef_web   <= 1'b0;
            coef_addrb <= 8'd0;
            coef_dinb  <= 23'd0;
`ifdef COEF_LOAD_REDUCE_EN
            s1_valid   <= 1'b0;
            s1_cnt     <= 7'd0;
            s1_even    <= 23'd0;
            s1_odd     <= 23'd0;
`endif
        end else begin
`ifdef COEF_LOAD_REDUCE_EN
            s1_valid <= accept;
            if (accept) begin
                s1_cnt  <= beat_cnt;
                s1_even <= c_even;
                s1_odd  <= c_odd;
            end
            coef_ena <= s1_valid;
            coef_wea <= s1_valid;
            coef_enb <= s1_valid;
            coef_web <= s1_valid;
            if (s1_valid) begin
                coef_addra <= {s1_cnt, 1'b0};
                coef_dina  <= reduce(s1_even);
                coef_addrb <= {s1_cnt, 1'b1};
                coef_dinb  <= reduce(s1_odd);
            end
`else
            coef_ena <= accept;
            coef_wea <= accept;
            coef_enb <= accept;
            coef_web <= accept;
            if (accept) begin
                coef_addra <= {beat_cnt, 1'b0};
                coef_dina  <= c_even;
                coef_addrb <= {beat_cnt, 1'b1};
                coef_dinb  <= c_odd;
            end
`endif
        end
    end

endmodule
